// File: rtl/alu_pkg.sv
// Shared definitions for the operand controller: FSM state encodings,
// data width and the default debounce length.
package alu_pkg;

    localparam int DATA_W        = 4;
    localparam int DB_CYCLES_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_B = 3'd1,
        ST_EXEC   = 3'd2,
        ST_CAPT   = 3'd3,
        ST_DONE   = 3'd4
    } alu_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: 2-flop synchroniser, stability counter and a
// single-cycle press pulse on each accepted 0->1 transition.
module btn_debounce #(
    parameter int DB_CYCLES = 16,
    parameter int DB_W      = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

    logic            sync1_r;
    logic            sync2_r;
    logic            clean_r;
    logic            press_r;
    logic [DB_W-1:0] cnt_r;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

    // Accept a new clean level only after DB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= {DB_W{1'b0}};
            clean_r <= 1'b0;
            press_r <= 1'b0;
        end else if (sync2_r != clean_r) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r   <= {DB_W{1'b0}};
                clean_r <= sync2_r;
                press_r <= sync2_r;
            end else begin
                cnt_r   <= cnt_r + DB_W'(1);
                press_r <= 1'b0;
            end
        end else begin
            cnt_r   <= {DB_W{1'b0}};
            press_r <= 1'b0;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/alu_operand_ctrl.sv
// Operand sequencer for a 4-bit adder: loads A then B from the switches,
// issues a one-cycle add command and captures the returned sum.
module alu_operand_ctrl #(
    parameter int DB_CYCLES = alu_pkg::DB_CYCLES_DEF,
    parameter int DB_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       btn_load,
    input  logic       btn_clr,
    input  logic [3:0] ans,
    output logic [3:0] reg0,
    output logic [3:0] reg1,
    output logic       enable_suma,
    output logic [3:0] result,
    output logic       done,
    output logic [2:0] state
);
    import alu_pkg::*;

    logic       load_press_s;
    logic       clr_press_s;
    alu_state_e state_r,  state_nxt_s;
    logic [3:0] reg0_r,   reg0_nxt_s;
    logic [3:0] reg1_r,   reg1_nxt_s;
    logic [3:0] result_r, result_nxt_s;
    logic       done_r,   done_nxt_s;
    logic       ena_r,    ena_nxt_s;

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_load (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_load),
        .press (load_press_s)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_clr),
        .press (clr_press_s)
    );

    // State and output registers; every output is driven straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            reg0_r   <= 4'd0;
            reg1_r   <= 4'd0;
            result_r <= 4'd0;
            done_r   <= 1'b0;
            ena_r    <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            reg0_r   <= reg0_nxt_s;
            reg1_r   <= reg1_nxt_s;
            result_r <= result_nxt_s;
            done_r   <= done_nxt_s;
            ena_r    <= ena_nxt_s;
        end
    end

    // Next-state and next-output logic; clear overrides any load press.
    always_comb begin
        state_nxt_s  = state_r;
        reg0_nxt_s   = reg0_r;
        reg1_nxt_s   = reg1_r;
        result_nxt_s = result_r;
        done_nxt_s   = done_r;
        ena_nxt_s    = 1'b0;
        if (clr_press_s) begin
            state_nxt_s  = ST_IDLE;
            reg0_nxt_s   = 4'd0;
            reg1_nxt_s   = 4'd0;
            result_nxt_s = 4'd0;
            done_nxt_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_press_s) begin
                        reg0_nxt_s  = sw;
                        state_nxt_s = ST_LOAD_B;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_LOAD_B: begin
                    // enable_suma is registered, so it is raised on entry to EXEC.
                    if (load_press_s) begin
                        reg1_nxt_s  = sw;
                        ena_nxt_s   = 1'b1;
                        state_nxt_s = ST_EXEC;
                    end else begin
                        state_nxt_s = ST_LOAD_B;
                    end
                end
                ST_EXEC: begin
                    state_nxt_s = ST_CAPT;
                end
                ST_CAPT: begin
                    result_nxt_s = ans;
                    done_nxt_s   = 1'b1;
                    state_nxt_s  = ST_DONE;
                end
                ST_DONE: begin
                    if (load_press_s) begin
                        done_nxt_s  = 1'b0;
                        reg0_nxt_s  = sw;
                        state_nxt_s = ST_LOAD_B;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    assign reg0        = reg0_r;
    assign reg1        = reg1_r;
    assign result      = result_r;
    assign done        = done_r;
    assign enable_suma = ena_r;
    assign state       = state_r;

endmodule
